// File: rtl/nn_pkg.sv
// Shared types and constants for the FP multiplier arbiter slice.
// Holds the FP32 word type, multiplier defaults and the arbiter FSM states.
package nn_pkg;

   typedef logic [31:0] fp32_t;

   localparam fp32_t FP_ZERO = 32'h0;
   localparam int FP_MULT_LAT = 3;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } arb_state_t;

endpackage

// File: rtl/fp_mult_arbiter_if.sv
// Requester-side bundle: operand requests in, tagged products out.
// master = layer engines, slave = arbiter.
interface fp_mult_arbiter_if
   import nn_pkg::*;
#(
   parameter int NUM_REQ = 4
);

   logic [NUM_REQ-1:0]  req_valid;
   fp32_t [NUM_REQ-1:0] req_a;
   fp32_t [NUM_REQ-1:0] req_b;
   logic [NUM_REQ-1:0]  req_ready;
   logic [NUM_REQ-1:0]  rsp_valid;
   fp32_t               rsp_q;

   modport master (
      output req_valid,
      output req_a,
      output req_b,
      input  req_ready,
      input  rsp_valid,
      input  rsp_q
   );

   modport slave (
      input  req_valid,
      input  req_a,
      input  req_b,
      output req_ready,
      output rsp_valid,
      output rsp_q
   );

endinterface

// File: rtl/tag_pipe.sv
// Valid + owner-tag shift register that tracks products inside the multiplier.
// Asynchronously cleared so a reset discards everything in flight.
module tag_pipe #(
   parameter int W     = 2,
   parameter int DEPTH = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [W-1:0]     in_tag,
   output logic [DEPTH-1:0] valid,
   output logic [W-1:0]     out_tag
);

   logic [DEPTH-1:0][W-1:0] tag;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid <= '0;
         tag   <= '0;
      end else begin
         valid[0] <= in_valid;
         tag[0]   <= in_tag;
         for (int i = 1; i < DEPTH; i++) begin
            valid[i] <= valid[i-1];
            tag[i]   <= tag[i-1];
         end
      end
   end

   assign out_tag = tag[DEPTH-1];

endmodule

// File: rtl/fp_mult_arbiter.sv
// Round-robin front end sharing one fixed-latency FP32 multiplier.
// Each product is routed back to its requester by a tag travelling alongside.
module fp_mult_arbiter
   import nn_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int MULT_LAT = FP_MULT_LAT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   fp_mult_arbiter_if.slave  bus,
   output fp32_t             mult_a,
   output fp32_t             mult_b,
   input  fp32_t             mult_q,
   output logic              busy
);

   localparam int W = $clog2(NUM_REQ);
   localparam logic [MULT_LAT-1:0] HEAD =
      ~(MULT_LAT'(1) << (MULT_LAT - 1));

   arb_state_t state;
   arb_state_t state_next;

   logic [W-1:0]        ptr;
   logic [W-1:0]        ptr_next;
   logic [W-1:0]        grant_idx;
   logic                grant_any;
   logic                can_grant;
   logic [MULT_LAT-1:0] pipe_v;
   logic [W-1:0]        pipe_tag;
   logic                pipe_filling;

   assign can_grant = reset && enable && (state != DRAIN);

   always_comb begin
      int idx;
      grant_any = 1'b0;
      grant_idx = '0;
      idx       = 0;
      for (int off = 0; off < NUM_REQ; off++) begin
         idx = int'(ptr) + off;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (can_grant && !grant_any && bus.req_valid[W'(idx)]) begin
            grant_any = 1'b1;
            grant_idx = W'(idx);
         end
      end
   end

   assign ptr_next = (grant_idx == W'(NUM_REQ - 1)) ?
                     '0 : grant_idx + W'(1);

   assign bus.req_ready = grant_any ?
                          (NUM_REQ'(1) << grant_idx) : '0;
   assign mult_a = grant_any ? bus.req_a[grant_idx] : FP_ZERO;
   assign mult_b = grant_any ? bus.req_b[grant_idx] : FP_ZERO;

   tag_pipe #(
      .W     (W),
      .DEPTH (MULT_LAT)
   ) u_tag_pipe (
      .clk      (clk),
      .reset    (reset),
      .in_valid (grant_any),
      .in_tag   (grant_idx),
      .valid    (pipe_v),
      .out_tag  (pipe_tag)
   );

   assign bus.rsp_valid = pipe_v[MULT_LAT-1] ?
                          (NUM_REQ'(1) << pipe_tag) : '0;
   assign bus.rsp_q = mult_q;

   // Only the last stage occupied means the pipe is empty next cycle,
   // so DRAIN may leave now and busy falls right after the final product.
   assign pipe_filling = |(pipe_v & HEAD);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         ptr   <= '0;
      end else begin
         state <= state_next;
         if (grant_any) ptr <= ptr_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (enable) state_next = RUN;
         RUN:     if (!enable) state_next = DRAIN;
         DRAIN: begin
            if (enable) state_next = RUN;
            else if (!pipe_filling) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE) || (|pipe_v);

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Directed bench: reset, single issue, contention, drain, wrap, mid-flight reset.
// A 3-stage behavioural FP32 multiplier sits on the mult port.
module tb_fp_mult_arbiter;
   import nn_pkg::*;

   logic  clk;
   logic  reset;
   logic  enable;
   fp32_t mult_a;
   fp32_t mult_b;
   fp32_t mult_q;
   logic  busy;
   fp32_t p0, p1, p2;

   int tests;
   int fails;

   fp_mult_arbiter_if #(.NUM_REQ(4)) bus ();

   fp_mult_arbiter #(
      .NUM_REQ  (4),
      .MULT_LAT (3)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .bus    (bus),
      .mult_a (mult_a),
      .mult_b (mult_b),
      .mult_q (mult_q),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // exact for normal operands whose product needs no rounding
   function automatic fp32_t fmul(input fp32_t a, input fp32_t b);
      logic [47:0] m;
      logic [9:0]  e;
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0)
         return {a[31] ^ b[31], 31'b0};
      m = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
      e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
      if (m[47])
         return {a[31] ^ b[31], e[7:0] + 8'd1, m[46:24]};
      return {a[31] ^ b[31], e[7:0], m[45:23]};
   endfunction

   always @(posedge clk) begin
      p0 <= fmul(mult_a, mult_b);
      p1 <= p0;
      p2 <= p1;
   end
   assign mult_q = p2;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [31:0] prod [4];
      logic [3:0]  oh;
      int k;
      tests = 0;
      fails = 0;
      prod[0] = 32'h40000000;
      prod[1] = 32'h40C00000;
      prod[2] = 32'h41800000;
      prod[3] = 32'h41400000;

      // reset held with every requester asking
      reset         = 1'b0;
      enable        = 1'b0;
      bus.req_valid = 4'hF;
      bus.req_a[0]  = 32'h3F800000;
      bus.req_b[0]  = 32'h40000000;
      bus.req_a[1]  = 32'h40000000;
      bus.req_b[1]  = 32'h40400000;
      bus.req_a[2]  = 32'h3F800000;
      bus.req_b[2]  = 32'h40000000;
      bus.req_a[3]  = 32'h40400000;
      bus.req_b[3]  = 32'h40800000;
      cyc();
      cyc();
      @(negedge clk);
      chk4("rst_ready", bus.req_ready, 4'b0000);
      chk4("rst_rsp_v", bus.rsp_valid, 4'b0000);
      chk1("rst_busy", busy, 1'b0);
      chk32("rst_mult_a", mult_a, 32'h0);
      chk32("rst_mult_b", mult_b, 32'h0);
      cyc();
      reset         = 1'b1;
      bus.req_valid = 4'h0;
      cyc();

      // single request from requester 2: 1.0 * 2.0
      enable        = 1'b1;
      bus.req_valid = 4'b0100;
      @(negedge clk);
      chk4("single_ready", bus.req_ready, 4'b0100);
      chk32("single_mult_a", mult_a, 32'h3F800000);
      chk32("single_mult_b", mult_b, 32'h40000000);
      cyc();
      bus.req_valid = 4'h0;
      @(negedge clk);
      chk4("single_rsp_c1", bus.rsp_valid, 4'b0000);
      chk1("single_busy", busy, 1'b1);
      cyc();
      @(negedge clk);
      chk4("single_rsp_c2", bus.rsp_valid, 4'b0000);
      cyc();
      @(negedge clk);
      chk4("single_rsp_c3", bus.rsp_valid, 4'b0100);
      chk32("single_rsp_q", bus.rsp_q, 32'h40000000);
      cyc();

      // requester 3 alone moves the pointer back to 0
      bus.req_valid = 4'b1000;
      @(negedge clk);
      chk4("r3_ready", bus.req_ready, 4'b1000);
      chk4("r3_rsp_c0", bus.rsp_valid, 4'b0000);
      cyc();
      bus.req_valid = 4'h0;
      cyc();
      cyc();
      @(negedge clk);
      chk4("r3_rsp_v", bus.rsp_valid, 4'b1000);
      chk32("r3_rsp_q", bus.rsp_q, 32'h41400000);
      cyc();

      // contention: all four valid for eight cycles
      bus.req_a[2] = 32'h40800000;
      bus.req_b[2] = 32'h40800000;
      for (int j = 0; j < 11; j++) begin
         bus.req_valid = (j < 8) ? 4'hF : 4'h0;
         @(negedge clk);
         oh = (j < 8) ? (4'b0001 << (j % 4)) : 4'b0000;
         chk4("cont_ready", bus.req_ready, oh);
         if (j >= 3) begin
            k  = (j - 3) % 4;
            oh = 4'b0001 << k;
            chk4("cont_rsp_v", bus.rsp_valid, oh);
            chk32("cont_rsp_q", bus.rsp_q, prod[k]);
         end else begin
            chk4("cont_rsp_idle", bus.rsp_valid, 4'b0000);
         end
         cyc();
      end
      @(negedge clk);
      chk4("cont_rsp_end", bus.rsp_valid, 4'b0000);
      cyc();

      // drain: three grants, then enable falls
      bus.req_valid = 4'hF;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         oh = 4'b0001 << j;
         chk4("drain_grant", bus.req_ready, oh);
         cyc();
      end
      enable = 1'b0;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         oh = 4'b0001 << j;
         chk4("drain_ready", bus.req_ready, 4'b0000);
         chk32("drain_mult_a", mult_a, 32'h0);
         chk4("drain_rsp_v", bus.rsp_valid, oh);
         chk32("drain_rsp_q", bus.rsp_q, prod[j]);
         chk1("drain_busy", busy, 1'b1);
         cyc();
      end
      @(negedge clk);
      chk4("drain_done_ready", bus.req_ready, 4'b0000);
      chk4("drain_done_rsp", bus.rsp_valid, 4'b0000);
      chk1("drain_busy_low", busy, 1'b0);
      cyc();

      // wrap: pointer sits at 3, requesters 0 and 3 waiting
      enable        = 1'b1;
      bus.req_valid = 4'b1001;
      @(negedge clk);
      chk4("wrap_first", bus.req_ready, 4'b1000);
      cyc();
      bus.req_valid = 4'b0001;
      @(negedge clk);
      chk4("wrap_second", bus.req_ready, 4'b0001);
      cyc();
      bus.req_valid = 4'b0011;
      @(negedge clk);
      chk4("wrap_ptr1", bus.req_ready, 4'b0010);
      cyc();
      bus.req_valid = 4'h0;
      @(negedge clk);
      chk4("wrap_rsp3", bus.rsp_valid, 4'b1000);
      chk32("wrap_q3", bus.rsp_q, prod[3]);
      cyc();
      @(negedge clk);
      chk4("wrap_rsp0", bus.rsp_valid, 4'b0001);
      chk32("wrap_q0", bus.rsp_q, prod[0]);
      cyc();
      @(negedge clk);
      chk4("wrap_rsp1", bus.rsp_valid, 4'b0010);
      chk32("wrap_q1", bus.rsp_q, prod[1]);
      cyc();

      // reset mid-flight with two products in the pipe
      bus.req_valid = 4'b0100;
      @(negedge clk);
      chk4("mid_grant2", bus.req_ready, 4'b0100);
      cyc();
      bus.req_valid = 4'b0010;
      @(negedge clk);
      chk4("mid_grant1", bus.req_ready, 4'b0010);
      cyc();
      bus.req_valid = 4'h0;
      reset         = 1'b0;
      @(negedge clk);
      chk4("mid_rst_rsp", bus.rsp_valid, 4'b0000);
      chk1("mid_rst_busy", busy, 1'b0);
      cyc();
      reset = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         chk4("mid_no_rsp", bus.rsp_valid, 4'b0000);
         cyc();
      end
      bus.req_valid = 4'b0110;
      @(negedge clk);
      chk4("mid_ptr0", bus.req_ready, 4'b0010);
      cyc();
      bus.req_valid = 4'h0;
      cyc();
      cyc();
      @(negedge clk);
      chk4("mid_new_rsp", bus.rsp_valid, 4'b0010);
      chk32("mid_new_q", bus.rsp_q, prod[1]);
      cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
